// File: rtl/hazard_control_unit_pkg.sv
`default_nettype none
// ============================================================================
// Module   : hazard_control_unit_pkg
// Purpose  : Shared types and constants for the hazard control unit:
//            scoreboard slot layout, register-index width, slot indices and
//            the slot liveness / operand-match helpers.
// Revision : 1.0 - initial release
// ============================================================================
package hazard_control_unit_pkg;

  localparam int REG_W     = 5;
  localparam logic [REG_W-1:0] X0 = '0;

  localparam int SLOT_EX   = 0;
  localparam int SLOT_MEM  = 1;
  localparam int SLOT_WB   = 2;
  localparam int NUM_SLOTS = 3;

  // One in-flight writer as seen by the shadow pipeline
  typedef struct packed {
    logic             valid;
    logic [REG_W-1:0] rd;
    logic             regwrite;
    logic             memread;
  } slot_t;

  // A slot only matters if it will really update a register other than x0
  function automatic logic slot_live(input slot_t s);
    return s.valid && s.regwrite && (s.rd != X0);
  endfunction

  // Live slot whose destination feeds an operand the ID instruction reads
  function automatic logic slot_matches(
    input slot_t            s,
    input logic             uses_rs1,
    input logic [REG_W-1:0] rs1,
    input logic             uses_rs2,
    input logic [REG_W-1:0] rs2
  );
    return slot_live(s) &&
           ((uses_rs1 && (s.rd == rs1)) || (uses_rs2 && (s.rd == rs2)));
  endfunction

endpackage
`default_nettype wire

// File: rtl/hazard_control_unit_if.sv
`default_nettype none
// ============================================================================
// Module   : hazard_control_unit_if
// Purpose  : Decode-side bundle between the pipeline and the hazard control
//            unit: ID instruction description in, pipeline controls and
//            event counters out.
// Revision : 1.0 - initial release
// ============================================================================
interface hazard_control_unit_if #(
  parameter int CNT_W = 32
);
  import hazard_control_unit_pkg::*;

  logic [REG_W-1:0] id_rs1;
  logic [REG_W-1:0] id_rs2;
  logic             id_uses_rs1;
  logic             id_uses_rs2;
  logic [REG_W-1:0] id_rd;
  logic             id_regwrite;
  logic             id_memread;
  logic             id_is_branch;
  logic             branch_taken;
  logic             mem_wait;

  logic             pc_write;
  logic             if_id_write;
  logic             if_id_flush;
  logic             id_ex_bubble;
  logic             freeze;
  logic             stall;
  logic [CNT_W-1:0] stall_cycles;
  logic [CNT_W-1:0] flush_count;

  // Pipeline side: describes the ID instruction, consumes the controls
  modport master (
    output id_rs1, id_rs2, id_uses_rs1, id_uses_rs2, id_rd,
           id_regwrite, id_memread, id_is_branch, branch_taken, mem_wait,
    input  pc_write, if_id_write, if_id_flush, id_ex_bubble, freeze,
           stall, stall_cycles, flush_count
  );

  // Hazard unit side
  modport slave (
    input  id_rs1, id_rs2, id_uses_rs1, id_uses_rs2, id_rd,
           id_regwrite, id_memread, id_is_branch, branch_taken, mem_wait,
    output pc_write, if_id_write, if_id_flush, id_ex_bubble, freeze,
           stall, stall_cycles, flush_count
  );

endinterface
`default_nettype wire

// File: rtl/hazard_control_unit_scoreboard.sv
`default_nettype none
// ============================================================================
// Module   : hazard_scoreboard
// Purpose  : Shadow EX/MEM/WB copy of every in-flight register writer.
//            Shifts one stage per edge, holds on memory wait, inserts an
//            invalid slot into EX when the ID instruction is being stalled,
//            and reports which slots feed an operand of the ID instruction.
// Revision : 1.0 - initial release
// ============================================================================
module hazard_scoreboard
  import hazard_control_unit_pkg::*;
(
  input  wire logic                 clk,
  input  wire logic                 rst,
  input  wire logic                 i_hold,
  input  wire logic                 i_bubble,
  input  wire slot_t                i_new_slot,
  input  wire logic [REG_W-1:0]     i_rs1,
  input  wire logic [REG_W-1:0]     i_rs2,
  input  wire logic                 i_uses_rs1,
  input  wire logic                 i_uses_rs2,
  output logic      [NUM_SLOTS-1:0] o_match,
  output logic      [NUM_SLOTS-1:0] o_memread
);

  slot_t slots_q [NUM_SLOTS];
  slot_t slots_d [NUM_SLOTS];

  // Next slot contents: hold everything, or advance with EX fed from ID
  always_comb begin
    slots_d = slots_q;
    if (!i_hold) begin
      slots_d[SLOT_WB]  = slots_q[SLOT_MEM];
      slots_d[SLOT_MEM] = slots_q[SLOT_EX];
      slots_d[SLOT_EX]  = i_bubble ? slot_t'('0) : i_new_slot;
    end
  end

  // Slot registers, cleared to invalid on reset
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      slots_q <= '{default: '0};
    end else begin
      slots_q <= slots_d;
    end
  end

  generate
    for (genvar gi = 0; gi < NUM_SLOTS; gi++) begin : g_slot_flags
      assign o_match[gi]   = slot_matches(slots_q[gi], i_uses_rs1, i_rs1,
                                          i_uses_rs2, i_rs2);
      assign o_memread[gi] = slots_q[gi].memread;
    end
  endgenerate

endmodule
`default_nettype wire

// File: rtl/hazard_control_unit.sv
`default_nettype none
// ============================================================================
// Module   : hazard_control_unit
// Purpose  : Decides when forwarding cannot cover a dependency of the ID
//            instruction and drives stall / bubble / flush / freeze for the
//            PC, IF/ID and ID/EX registers. Counts stall and flush cycles
//            with saturating counters.
// Revision : 1.0 - initial release
// ============================================================================
module hazard_control_unit
  import hazard_control_unit_pkg::*;
#(
  parameter int CNT_W = 32
) (
  input  wire logic            clk,
  input  wire logic            rst,
  hazard_control_unit_if.slave bus
);

  logic [NUM_SLOTS-1:0] w_match;
  logic [NUM_SLOTS-1:0] w_memread;
  slot_t                w_new_slot;
  logic                 w_load_use;
  logic                 w_branch_hz;
  logic                 w_stall;
  logic                 w_flush;

  logic [CNT_W-1:0]     stall_cycles_q;
  logic [CNT_W-1:0]     stall_cycles_d;
  logic [CNT_W-1:0]     flush_count_q;
  logic [CNT_W-1:0]     flush_count_d;

  assign w_new_slot = '{valid:    1'b1,
                        rd:       bus.id_rd,
                        regwrite: bus.id_regwrite,
                        memread:  bus.id_memread};

  hazard_scoreboard u_scoreboard (
    .clk        (clk),
    .rst        (rst),
    .i_hold     (bus.mem_wait),
    .i_bubble   (w_stall),
    .i_new_slot (w_new_slot),
    .i_rs1      (bus.id_rs1),
    .i_rs2      (bus.id_rs2),
    .i_uses_rs1 (bus.id_uses_rs1),
    .i_uses_rs2 (bus.id_uses_rs2),
    .o_match    (w_match),
    .o_memread  (w_memread)
  );

  // Load data is not ready to forward until after MEM; branches compare in
  // ID and can only take a forward from EX/MEM, so an ALU result still in
  // EX or load data still in MEM forces a wait. WB is covered by the
  // register file's write-before-read.
  assign w_load_use  = w_match[SLOT_EX] & w_memread[SLOT_EX];
  assign w_branch_hz = bus.id_is_branch &
                       (w_match[SLOT_EX] |
                        (w_match[SLOT_MEM] & w_memread[SLOT_MEM]));

  // A memory wait freezes everything and outranks the stall
  assign w_stall = (w_load_use | w_branch_hz) & ~bus.mem_wait;
  assign w_flush = bus.branch_taken & ~w_stall & ~bus.mem_wait;

  assign bus.stall        = w_stall;
  assign bus.freeze       = bus.mem_wait;
  assign bus.pc_write     = ~bus.mem_wait & ~w_stall;
  assign bus.if_id_write  = ~bus.mem_wait & ~w_stall;
  assign bus.id_ex_bubble = w_stall;
  assign bus.if_id_flush  = w_flush;
  assign bus.stall_cycles = stall_cycles_q;
  assign bus.flush_count  = flush_count_q;

  // Saturating event counters: stop at all-ones instead of wrapping
  always_comb begin
    stall_cycles_d = stall_cycles_q;
    flush_count_d  = flush_count_q;
    if (w_stall && (stall_cycles_q != '1)) begin
      stall_cycles_d = stall_cycles_q + 1'b1;
    end
    if (w_flush && (flush_count_q != '1)) begin
      flush_count_d = flush_count_q + 1'b1;
    end
  end

  // Counter registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stall_cycles_q <= '0;
      flush_count_q  <= '0;
    end else begin
      stall_cycles_q <= stall_cycles_d;
      flush_count_q  <= flush_count_d;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_hazard_control_unit.sv
`default_nettype none
// ============================================================================
// Module   : tb_hazard_control_unit
// Purpose  : Directed and random stimulus for hazard_control_unit, checked
//            against an instruction-level model of the in-flight writers.
// Revision : 1.0 - initial release
// ============================================================================
module tb_hazard_control_unit;

  localparam int CNT_W = 4;
  localparam int CMAX  = (1 << CNT_W) - 1;

  logic clk = 1'b0;
  logic rst = 1'b1;

  hazard_control_unit_if #(.CNT_W(CNT_W)) bus ();

  hazard_control_unit #(.CNT_W(CNT_W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  int n_assert = 0;
  int n_fail   = 0;

  // Model: age-ordered list of the three youngest issued instructions
  // (index 0 = issued last edge). A stalled edge issues nothing.
  int m_valid [3];
  int m_rd    [3];
  int m_rw    [3];
  int m_ld    [3];
  int m_stall_cnt;
  int m_flush_cnt;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Does instruction of age k produce a register the ID instruction reads?
  function automatic bit feeds(int k);
    if (m_valid[k] == 0 || m_rw[k] == 0 || m_rd[k] == 0) return 1'b0;
    return (bus.id_uses_rs1 && m_rd[k] == int'(bus.id_rs1)) ||
           (bus.id_uses_rs2 && m_rd[k] == int'(bus.id_rs2));
  endfunction

  task automatic model_clear();
    for (int i = 0; i < 3; i++) begin
      m_valid[i] = 0; m_rd[i] = 0; m_rw[i] = 0; m_ld[i] = 0;
    end
    m_stall_cnt = 0;
    m_flush_cnt = 0;
  endtask

  task automatic drive(input int rd, input bit rw, input bit ld,
                       input int rs1, input bit u1, input int rs2, input bit u2,
                       input bit br, input bit tk, input bit mw);
    bus.id_rd        = 5'(rd);
    bus.id_regwrite  = rw;
    bus.id_memread   = ld;
    bus.id_rs1       = 5'(rs1);
    bus.id_uses_rs1  = u1;
    bus.id_rs2       = 5'(rs2);
    bus.id_uses_rs2  = u2;
    bus.id_is_branch = br;
    bus.branch_taken = tk;
    bus.mem_wait     = mw;
  endtask

  // One pipeline cycle: present ID instruction, check controls, clock, check counters
  task automatic step(input int rd, input bit rw, input bit ld,
                      input int rs1, input bit u1, input int rs2, input bit u2,
                      input bit br, input bit tk, input bit mw);
    bit need_wait, e_stall, e_flush;
    drive(rd, rw, ld, rs1, u1, rs2, u2, br, tk, mw);
    #2;
    need_wait = (feeds(0) && m_ld[0] != 0) ||
                (br && (feeds(0) || (feeds(1) && m_ld[1] != 0)));
    e_stall = need_wait && !mw;
    e_flush = tk && !e_stall && !mw;
    chk("stall",        32'(bus.stall),        32'(e_stall));
    chk("id_ex_bubble", 32'(bus.id_ex_bubble), 32'(e_stall));
    chk("pc_write",     32'(bus.pc_write),     32'(!mw && !e_stall));
    chk("if_id_write",  32'(bus.if_id_write),  32'(!mw && !e_stall));
    chk("if_id_flush",  32'(bus.if_id_flush),  32'(e_flush));
    chk("freeze",       32'(bus.freeze),       32'(mw));
    @(posedge clk);
    #1;
    if (!mw) begin
      for (int i = 2; i > 0; i--) begin
        m_valid[i] = m_valid[i-1]; m_rd[i] = m_rd[i-1];
        m_rw[i] = m_rw[i-1]; m_ld[i] = m_ld[i-1];
      end
      m_valid[0] = e_stall ? 0 : 1;
      m_rd[0] = rd; m_rw[0] = rw; m_ld[0] = ld;
    end
    if (e_stall) m_stall_cnt = (m_stall_cnt < CMAX) ? m_stall_cnt + 1 : CMAX;
    if (e_flush) m_flush_cnt = (m_flush_cnt < CMAX) ? m_flush_cnt + 1 : CMAX;
    chk("stall_cycles", 32'(bus.stall_cycles), 32'(m_stall_cnt));
    chk("flush_count",  32'(bus.flush_count),  32'(m_flush_cnt));
  endtask

  task automatic nop();
    step(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  // Asynchronous reset between edges; outputs must react before any edge
  task automatic do_reset();
    rst = 1'b1;
    #1;
    model_clear();
    chk("rst_pc_write",     32'(bus.pc_write),     32'd1);
    chk("rst_if_id_write",  32'(bus.if_id_write),  32'd1);
    chk("rst_stall",        32'(bus.stall),        32'd0);
    chk("rst_bubble",       32'(bus.id_ex_bubble), 32'd0);
    chk("rst_flush",        32'(bus.if_id_flush),  32'd0);
    chk("rst_freeze",       32'(bus.freeze),       32'd0);
    chk("rst_stall_cycles", 32'(bus.stall_cycles), 32'd0);
    chk("rst_flush_count",  32'(bus.flush_count),  32'd0);
    @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  initial begin
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    do_reset();

    // lw x5 ; add x6,x5,x1 -> one stall cycle
    step(5, 1, 1, 0, 0, 0, 0, 0, 0, 0);
    step(6, 1, 0, 5, 1, 1, 1, 0, 0, 0);
    step(6, 1, 0, 5, 1, 1, 1, 0, 0, 0);
    chk("lu_stall_cycles", 32'(bus.stall_cycles), 32'd1);

    // add x5 ; beq x5,x0 -> one stall cycle
    do_reset();
    step(5, 1, 0, 1, 1, 2, 1, 0, 0, 0);
    step(0, 0, 0, 5, 1, 0, 1, 1, 0, 0);
    step(0, 0, 0, 5, 1, 0, 1, 1, 0, 0);
    chk("alu_br_stall_cycles", 32'(bus.stall_cycles), 32'd1);

    // lw x5 ; beq x5,x0 -> two stall cycles
    do_reset();
    step(5, 1, 1, 1, 1, 0, 0, 0, 0, 0);
    step(0, 0, 0, 5, 1, 0, 1, 1, 0, 0);
    step(0, 0, 0, 5, 1, 0, 1, 1, 0, 0);
    step(0, 0, 0, 5, 1, 0, 1, 1, 0, 0);
    chk("ld_br_stall_cycles", 32'(bus.stall_cycles), 32'd2);

    // independent taken branch -> single flush
    do_reset();
    step(7, 1, 0, 1, 1, 2, 1, 0, 0, 0);
    step(0, 0, 0, 5, 1, 0, 1, 1, 1, 0);
    nop();
    chk("br_flush_count", 32'(bus.flush_count), 32'd1);
    chk("br_stall_cycles", 32'(bus.stall_cycles), 32'd0);

    // x0 never hazards; WB-slot match never stalls
    do_reset();
    step(0, 1, 1, 1, 1, 0, 0, 0, 0, 0);
    step(6, 1, 0, 0, 1, 0, 1, 0, 0, 0);
    step(5, 1, 0, 1, 1, 2, 1, 0, 0, 0);
    nop();
    nop();
    step(6, 1, 0, 5, 1, 1, 1, 0, 0, 0);
    chk("x0_wb_stall_cycles", 32'(bus.stall_cycles), 32'd0);

    // load-use held by mem_wait for 3 cycles, then one stall
    do_reset();
    step(5, 1, 1, 1, 1, 0, 0, 0, 0, 0);
    for (int i = 0; i < 3; i++) step(6, 1, 0, 5, 1, 1, 1, 0, 0, 1);
    step(6, 1, 0, 5, 1, 1, 1, 0, 0, 0);
    step(6, 1, 0, 5, 1, 1, 1, 0, 0, 0);
    chk("mw_stall_cycles", 32'(bus.stall_cycles), 32'd1);

    // reset asserted while a stall is being driven
    do_reset();
    step(5, 1, 1, 1, 1, 0, 0, 0, 0, 0);
    step(6, 1, 0, 5, 1, 1, 1, 0, 0, 0);
    step(6, 1, 0, 5, 1, 1, 1, 0, 0, 0);
    step(5, 1, 1, 1, 1, 0, 0, 0, 0, 0);
    drive(6, 1, 0, 5, 1, 1, 1, 0, 0, 0);
    #2;
    chk("pre_rst_stall", 32'(bus.stall), 32'd1);
    do_reset();

    // saturation: 20 load-use stalls into a 4-bit counter
    for (int i = 0; i < 20; i++) begin
      step(5, 1, 1, 1, 1, 0, 0, 0, 0, 0);
      step(6, 1, 0, 5, 1, 1, 1, 0, 0, 0);
      step(6, 1, 0, 5, 1, 1, 1, 0, 0, 0);
    end
    chk("sat_stall_cycles", 32'(bus.stall_cycles), 32'(CMAX));

    // random mix against the model
    do_reset();
    for (int i = 0; i < 400; i++) begin
      bit br;
      br = ($urandom_range(0, 3) == 0);
      step($urandom_range(0, 7), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 2) == 0),
           $urandom_range(0, 7), 1'($urandom_range(0, 3) != 0),
           $urandom_range(0, 7), 1'($urandom_range(0, 1)),
           br, br && ($urandom_range(0, 1) == 1), 1'($urandom_range(0, 6) == 0));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/hazard_control_unit.md
Name: hazard_control_unit

Overview:
- Producer-side partner of the forwarding logic. Tracks every in-flight register writer in a shadow EX/MEM/WB scoreboard.
- Decides when forwarding cannot cover a dependency and drives the pipeline controls: stall, bubble, flush and freeze.
- Sits beside the decode stage. Its outputs gate PC, IF/ID and ID/EX register enables. Includes performance counters.

Parameters:
- CNT_W, 32, width of the stall and flush event counters (saturating).

Ports:
- clk  in  1  pipeline clock.
- rst  in  1  asynchronous active-high reset.
- id_rs1  in  5  rs1 of the instruction in ID.
- id_rs2  in  5  rs2 of the instruction in ID.
- id_uses_rs1  in  1  ID instruction reads rs1.
- id_uses_rs2  in  1  ID instruction reads rs2.
- id_rd  in  5  destination register of the ID instruction.
- id_regwrite  in  1  ID instruction writes rd.
- id_memread  in  1  ID instruction is a load.
- id_is_branch  in  1  ID instruction is a branch/jalr resolved in ID.
- branch_taken  in  1  branch in ID resolved taken this cycle.
- mem_wait  in  1  data memory not ready; whole pipeline must hold.
- pc_write  out  1  PC enable.
- if_id_write  out  1  IF/ID enable.
- if_id_flush  out  1  zero IF/ID on the next edge.
- id_ex_bubble  out  1  load a NOP into ID/EX on the next edge.
- freeze  out  1  hold EX/MEM and MEM/WB.
- stall  out  1  a data-hazard stall is active.
- stall_cycles  out  CNT_W  count of cycles with stall=1.
- flush_count  out  CNT_W  count of cycles with if_id_flush=1.

Behaviour:
- Scoreboard: three slots, EX, MEM and WB. Each slot holds {valid, rd, regwrite, memread}. A slot is live only if valid && regwrite && rd!=0.
- Match rule: a slot matches if it is live and (id_uses_rs1 && rd==id_rs1) or (id_uses_rs2 && rd==id_rs2).
- Load-use stall: the EX slot matches and has memread=1. Applies to any ID instruction.
- Branch stall (branches read operands in ID; the only ID-stage forward source is EX/MEM):
  - the EX slot matches (any live writer), or
  - the MEM slot matches and has memread=1.
- WB-slot matches never stall; the register file provides write-before-read.
- stall = (load-use stall or branch stall) && !mem_wait.
- Priority: mem_wait > stall > branch_taken.
  - mem_wait=1: freeze=1, pc_write=0, if_id_write=0, id_ex_bubble=0, if_id_flush=0. The scoreboard holds every slot.
  - stall=1: pc_write=0, if_id_write=0, id_ex_bubble=1, if_id_flush=0. branch_taken is ignored.
  - branch_taken && !stall && !mem_wait: if_id_flush=1; PC and IF/ID enabled.
- Scoreboard advance (every edge unless mem_wait): WB<=MEM, MEM<=EX.
  - EX <= {1, id_rd, id_regwrite, id_memread}, or an invalid slot when stall=1.
  - A flushed IF/ID produces a NOP in ID on the following cycle; the core presents id_regwrite=0 for it.
- Outputs are combinational from the slots and the inputs; counters and slots are registered.
- Latency:
  - Load followed by a dependent ALU op: exactly 1 stall cycle.
  - Branch after a dependent ALU op: 1 stall cycle.
  - Branch after a dependent load: 2 stall cycles.
  - Branch after an independent op: 0 stall cycles.
- Counters increment on each clk edge where their event is high. They saturate at all-ones and do not wrap.
- Reset (asynchronous, any time, including mid-stall): all slots invalid, counters 0.
  - Outputs after reset: pc_write=1, if_id_write=1, stall=0, id_ex_bubble=0, if_id_flush=0, freeze=0.
- x0 is never a hazard, even with regwrite=1.

Decomposition:
- Shared package holds:
  - slot typedef {valid, rd[4:0], regwrite, memread};
  - REG_W=5 and X0 constant;
  - slot indices SLOT_EX/SLOT_MEM/SLOT_WB.
- One natural sub-module: hazard_scoreboard, which holds the three-slot shift register with hold/bubble insert and exposes per-slot match flags.
- Stall/flush priority logic and counters stay in the top.

Test Plan:
- `lw x5` then `add x6,x5,x1` -> exactly one cycle of stall=1, id_ex_bubble=1, pc_write=0; next cycle stall=0; stall_cycles=1.
- `add x5` then `beq x5,x0` -> 1 stall cycle. `lw x5` then `beq x5,x0` -> 2 consecutive stall cycles; stall_cycles=2.
- `beq` independent of older writers with branch_taken=1 -> if_id_flush=1 for 1 cycle; flush_count=1; stall=0.
- `lw x0` then `add x6,x0,x0` -> no stall. `add x5` then 2 NOPs, then `add x6,x5` (WB-slot match) -> no stall.
- Load-use in ID with mem_wait=1 for 3 cycles -> freeze=1 and stall=0 for those cycles; after release, stall=1 for 1 cycle; slots not lost.
- rst pulse asserted mid-stall (between edges) -> outputs return immediately to reset values, counters read 0; stall counter saturates at 2^CNT_W-1 (test with CNT_W=4).
